// File: rtl/intp_req_capture.sv
// Interrupt request capture front end.
// Samples raw peripheral interrupt lines into per-source pending bits (rising-edge or level mode),
// masks them onto intp_active_o and clears edge-captured bits on controller service or on a
// write-1-to-clear. Configuration and status are exposed through a zero-wait-state APB slave.
// Optional macro INTP_SYNC_EN: inserts a 2-flop synchroniser per irq line (+2 cycles latency).
module intp_req_capture #(
  parameter int unsigned NUM_OF_PERIPHERALS = 16,
  parameter int unsigned ADDR_WIDTH         = 2,
  parameter int unsigned IDX_WIDTH          = $clog2(NUM_OF_PERIPHERALS)
) (
  input  logic                          pclk_i,
  input  logic                          prst_i,
  input  logic [ADDR_WIDTH-1:0]         paddr_i,
  input  logic                          pwrite_i,
  input  logic                          penable_i,
  input  logic [NUM_OF_PERIPHERALS-1:0] pwdata_i,
  output logic [NUM_OF_PERIPHERALS-1:0] prdata_o,
  output logic                          pready_o,
  output logic                          perror_o,
  input  logic [NUM_OF_PERIPHERALS-1:0] irq_raw_i,
  input  logic                          intp_serviced_i,
  input  logic [IDX_WIDTH-1:0]          intp_to_service_i,
  output logic [NUM_OF_PERIPHERALS-1:0] intp_active_o
);

  localparam int unsigned N = NUM_OF_PERIPHERALS;

  localparam logic [1:0] AddrMode    = 2'd0;
  localparam logic [1:0] AddrMask    = 2'd1;
  localparam logic [1:0] AddrPending = 2'd2;
  localparam logic [1:0] AddrClear   = 2'd3;

  logic [N-1:0] irq_smp;

`ifdef INTP_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser for asynchronous peripheral lines.
  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_smp = sync2_q;
`else
  assign irq_smp = irq_raw_i;
`endif

  logic [N-1:0] mode_q, mode_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] hist_q;
  logic [N-1:0] active_q, active_d;
  logic [N-1:0] prdata_q, prdata_d;
  logic         pready_q, pready_d;
  logic         perror_q, perror_d;

  logic [1:0]   addr_lo;
  logic         addr_oob;
  logic         acc_err;
  logic         wr_en;
  logic [N-1:0] mode_chg;
  logic [N-1:0] svc_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] rise_vec;

  // Addresses above the four-word map only exist when the bus is wider than 2 bits.
  if (ADDR_WIDTH > 2) begin : g_oob
    assign addr_oob = |paddr_i[ADDR_WIDTH-1:2];
  end else begin : g_no_oob
    assign addr_oob = 1'b0;
  end

  assign addr_lo = paddr_i[1:0];

  // APB decode and registered response.
  always_comb begin
    acc_err  = penable_i & (addr_oob | (pwrite_i & (addr_lo == AddrPending)));
    wr_en    = penable_i & pwrite_i & ~acc_err;
    pready_d = penable_i;
    perror_d = acc_err;
    prdata_d = '0;
    if (penable_i && !pwrite_i && !acc_err) begin
      unique case (addr_lo)
        AddrMode:    prdata_d = mode_q;
        AddrMask:    prdata_d = mask_q;
        AddrPending: prdata_d = pend_q;
        AddrClear:   prdata_d = '0;
        default:     prdata_d = '0;
      endcase
    end
  end

  // Configuration writes and clear sources.
  always_comb begin
    mode_d = mode_q;
    mask_d = mask_q;
    if (wr_en && (addr_lo == AddrMode)) mode_d = pwdata_i;
    if (wr_en && (addr_lo == AddrMask)) mask_d = pwdata_i;
    mode_chg = mode_q ^ mode_d;
    // Out-of-range service indices match no bit and are thereby ignored.
    for (int unsigned i = 0; i < N; i++) begin
      svc_vec[i] = intp_serviced_i && (intp_to_service_i == IDX_WIDTH'(i));
    end
    clr_vec = svc_vec | ((wr_en && (addr_lo == AddrClear)) ? pwdata_i : '0);
  end

  // Pending next state: set beats clear in edge mode; level mode follows the sample.
  always_comb begin
    rise_vec = irq_smp & ~hist_q;
    pend_d   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mode_chg[i]) begin
        pend_d[i] = 1'b0;
      end else if (mode_q[i]) begin
        pend_d[i] = rise_vec[i] | (pend_q[i] & ~clr_vec[i]);
      end else begin
        pend_d[i] = irq_smp[i];
      end
    end
    active_d = pend_q & mask_q;
  end

  // State registers; edge history always tracks the sample so a mode switch sees no false edge.
  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      mode_q   <= '1;
      mask_q   <= '1;
      pend_q   <= '0;
      hist_q   <= '0;
      active_q <= '0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      perror_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      hist_q   <= irq_smp;
      active_q <= active_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
      perror_q <= perror_d;
    end
  end

  assign prdata_o      = prdata_q;
  assign pready_o      = pready_q;
  assign perror_o      = perror_q;
  assign intp_active_o = active_q;

endmodule

// File: tb/tb_intp_req_capture.sv
// Self-checking bench for intp_req_capture: reset, register table, directed corner sequences and
// a randomized run, all compared cycle by cycle against a behavioural model.
module tb_intp_req_capture;

  localparam int unsigned N = 16;
`ifdef INTP_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          prst;
  logic [1:0]    paddr;
  logic          pwrite;
  logic          penable;
  logic [N-1:0]  pwdata;
  logic [N-1:0]  prdata;
  logic          pready;
  logic          perror;
  logic [N-1:0]  irq;
  logic          serviced;
  logic [3:0]    idx;
  logic [N-1:0]  active;

  int checks = 0;
  int errors = 0;

  intp_req_capture #(
    .NUM_OF_PERIPHERALS(N),
    .ADDR_WIDTH(2)
  ) dut (
    .pclk_i            (clk),
    .prst_i            (prst),
    .paddr_i           (paddr),
    .pwrite_i          (pwrite),
    .penable_i         (penable),
    .pwdata_i          (pwdata),
    .prdata_o          (prdata),
    .pready_o          (pready),
    .perror_o          (perror),
    .irq_raw_i         (irq),
    .intp_serviced_i   (serviced),
    .intp_to_service_i (idx),
    .intp_active_o     (active)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [N-1:0] m_mode, m_mask, m_pend, m_prev, m_act, m_rd, m_s1, m_s2;
  logic         m_rdy, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic tick();
    logic [N-1:0] n_mode, n_mask, n_pend, n_prev, n_act, n_rd, n_s1, n_s2, smp, chg, clr;
    logic         n_rdy, n_err, wr;
    if (!prst) begin
      n_mode = '1; n_mask = '1; n_pend = '0; n_prev = '0; n_act = '0; n_rd = '0;
      n_rdy = 1'b0; n_err = 1'b0; n_s1 = '0; n_s2 = '0;
    end else begin
`ifdef INTP_SYNC_EN
      smp = m_s2; n_s1 = irq; n_s2 = m_s1;
`else
      smp = irq; n_s1 = '0; n_s2 = '0;
`endif
      n_err = penable && pwrite && (paddr == 2'd2);
      wr    = penable && pwrite && !n_err;
      n_rdy = penable;
      n_rd  = '0;
      if (penable && !pwrite && !n_err) begin
        if (paddr == 2'd0) n_rd = m_mode;
        else if (paddr == 2'd1) n_rd = m_mask;
        else if (paddr == 2'd2) n_rd = m_pend;
      end
      n_mode = (wr && paddr == 2'd0) ? pwdata : m_mode;
      n_mask = (wr && paddr == 2'd1) ? pwdata : m_mask;
      chg    = m_mode ^ n_mode;
      clr    = (wr && paddr == 2'd3) ? pwdata : '0;
      if (serviced && idx < N) clr[idx] = 1'b1;
      n_act  = m_pend & m_mask;
      for (int i = 0; i < N; i++) begin
        if (chg[i]) n_pend[i] = 1'b0;
        else if (m_mode[i]) n_pend[i] = (smp[i] && !m_prev[i]) || (m_pend[i] && !clr[i]);
        else n_pend[i] = smp[i];
      end
      n_prev = smp;
    end
    @(posedge clk);
    #1;
    m_mode = n_mode; m_mask = n_mask; m_pend = n_pend; m_prev = n_prev; m_act = n_act;
    m_rd = n_rd; m_rdy = n_rdy; m_err = n_err; m_s1 = n_s1; m_s2 = n_s2;
    chk("model_active", active, m_act);
    chk("model_prdata", prdata, m_rd);
    chk("model_pready", pready, m_rdy);
    chk("model_perror", perror, m_err);
  endtask

  task automatic apb(input logic wr, input logic [1:0] a, input logic [N-1:0] d);
    paddr = a; pwrite = wr; pwdata = d; penable = 1'b1;
    tick();
    penable = 1'b0; pwrite = 1'b0; pwdata = '0;
  endtask

  typedef struct {
    logic         wr;
    logic [1:0]   addr;
    logic [N-1:0] wdata;
    logic [N-1:0] exp_rd;
    logic         exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 2'd0, 16'hA5A5, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 16'h0000, 16'hA5A5, 1'b0};
    vecs[2]  = '{1'b1, 2'd1, 16'h1234, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 2'd1, 16'h0000, 16'h1234, 1'b0};
    vecs[4]  = '{1'b1, 2'd2, 16'hFFFF, 16'h0000, 1'b1};
    vecs[5]  = '{1'b0, 2'd2, 16'h0000, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 2'd3, 16'h0000, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 2'd3, 16'hFFFF, 16'h0000, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 16'hFFFF, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 2'd1, 16'hFFFF, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 16'h0000, 16'hFFFF, 1'b0};
    vecs[11] = '{1'b0, 2'd1, 16'h0000, 16'hFFFF, 1'b0};

    // Reset with all lines high and a write in flight that must be discarded
    prst = 1'b0; irq = '1; serviced = 1'b0; idx = '0;
    paddr = 2'd0; pwrite = 1'b1; penable = 1'b1; pwdata = '0;
    repeat (3) tick();
    chk("reset_active", active, 16'h0000);
    chk("reset_pready", pready, 1'b0);
    chk("reset_perror", perror, 1'b0);
    chk("reset_prdata", prdata, 16'h0000);
    penable = 1'b0; pwrite = 1'b0; irq = '0; prst = 1'b1;
    tick();
    apb(1'b0, 2'd0, '0);
    chk("reset_mode", prdata, 16'hFFFF);
    chk("reset_pready_acc", pready, 1'b1);
    apb(1'b0, 2'd1, '0);
    chk("reset_mask", prdata, 16'hFFFF);
    tick();
    chk("pready_idle", pready, 1'b0);

    // Register table
    for (int v = 0; v < 12; v++) begin
      apb(vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      chk($sformatf("vec%0d_prdata", v), prdata, vecs[v].exp_rd);
      chk($sformatf("vec%0d_perror", v), perror, vecs[v].exp_err);
    end
    tick();

    // Edge capture and service
    irq[5] = 1'b1; tick(); irq[5] = 1'b0;
    chk("edge_early0", active, 16'h0000);
    repeat (LAT - 2) tick();
    chk("edge_early1", active, 16'h0000);
    tick();
    chk("edge_latency", active, 16'h0020);
    repeat (3) tick();
    chk("edge_held", active, 16'h0020);
    serviced = 1'b1; idx = 4'd5; tick(); serviced = 1'b0;
    tick();
    chk("edge_serviced", active, 16'h0000);

    // Level mode
    apb(1'b1, 2'd0, 16'hFFFE);
    irq[0] = 1'b1;
    repeat (LAT + 1) tick();
    chk("level_on", active[0], 1'b1);
    serviced = 1'b1; idx = 4'd0; tick(); serviced = 1'b0;
    tick();
    chk("level_svc_ignored", active[0], 1'b1);
    irq[0] = 1'b0;
    repeat (LAT - 1) tick();
    chk("level_drop_early", active[0], 1'b1);
    tick();
    chk("level_drop", active[0], 1'b0);
    apb(1'b1, 2'd0, 16'hFFFF);
    repeat (2) tick();

    // Mask holds back a captured edge
    apb(1'b1, 2'd1, 16'h0000);
    irq[3] = 1'b1; tick(); irq[3] = 1'b0;
    repeat (LAT) tick();
    chk("mask_active", active, 16'h0000);
    apb(1'b0, 2'd2, '0);
    chk("mask_pending", prdata, 16'h0008);
    apb(1'b1, 2'd1, 16'hFFFF);
    tick();
    chk("unmask_active", active, 16'h0008);
    apb(1'b1, 2'd3, 16'h0008);
    tick();
    chk("clear3_active", active, 16'h0000);

    // Collision: new edge at the same edge as service -> stays pending
    irq[7] = 1'b1; tick(); irq[7] = 1'b0;
    repeat (LAT) tick();
    chk("coll_pre", active[7], 1'b1);
    irq[7] = 1'b1;
    repeat (LAT - 2) tick();
    serviced = 1'b1; idx = 4'd7; tick(); serviced = 1'b0;
    tick();
    chk("coll_kept", active[7], 1'b1);
    apb(1'b0, 2'd2, '0);
    chk("coll_pending", prdata, 16'h0080);
    apb(1'b1, 2'd3, 16'h0080);
    tick();
    chk("coll_cleared", active, 16'h0000);
    irq[7] = 1'b0;
    repeat (LAT) tick();

    // APB errors
    irq[1] = 1'b1; tick(); irq[1] = 1'b0;
    repeat (LAT) tick();
    apb(1'b1, 2'd2, 16'h0000);
    chk("err_wr2_perror", perror, 1'b1);
    chk("err_wr2_pready", pready, 1'b1);
    apb(1'b0, 2'd2, '0);
    chk("err_pend_kept", prdata, 16'h0002);
    apb(1'b0, 2'd3, '0);
    chk("rd3_prdata", prdata, 16'h0000);
    chk("rd3_perror", perror, 1'b0);
    apb(1'b1, 2'd3, 16'h0002);
    repeat (2) tick();

    // Randomized run against the model
    for (int c = 0; c < 400; c++) begin
      irq      = irq ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      serviced = ($urandom_range(0, 3) == 0);
      idx      = 4'($urandom);
      penable  = ($urandom_range(0, 3) == 0);
      pwrite   = 1'($urandom_range(0, 1));
      paddr    = 2'($urandom);
      pwdata   = 16'($urandom);
      tick();
    end
    penable = 1'b0; pwrite = 1'b0; serviced = 1'b0; irq = '0;
    repeat (LAT + 2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
